// File: rtl/softmax_row_feeder_if.sv
// Handshake bundle between the systolic output buffer, the row feeder and softmax.
//   col_valid/col_data : skewed per-column results (column j at [DATA_W*j +: DATA_W])
//   Xi/softmax_en      : aligned row presented to softmax, same packing
//   softmax_ready      : softmax accepts Xi this cycle
// slave modport is the feeder's view; master is the surrounding environment.
interface softmax_row_feeder_if #(
  parameter int ARRAYWIDTH = 4,
  parameter int DATA_W     = 32
);
  logic [ARRAYWIDTH-1:0]        col_valid;
  logic [ARRAYWIDTH*DATA_W-1:0] col_data;
  logic [ARRAYWIDTH*DATA_W-1:0] Xi;
  logic                         softmax_en;
  logic                         softmax_ready;

  modport slave  (input  col_valid, col_data, softmax_ready, output Xi, softmax_en);
  modport master (output col_valid, col_data, softmax_ready, input  Xi, softmax_en);
endinterface

// File: rtl/softmax_row_feeder.sv
// Deskew-and-buffer stage in front of softmax. Each column is delayed so that all
// elements of a row line up, complete rows go into a show-ahead FIFO, and the head
// row is offered to softmax with a valid/ready handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : column inputs and softmax handshake (slave modport)
//   clr_flags  : synchronous clear of sticky flags (a same-cycle event wins)
//   overflow   : sticky, a complete row was dropped on a full FIFO
//   skew_err   : sticky, aligned valids disagreed (row discarded)
//   row_cnt    : rows handed to softmax, wraps at 2^16

// One column's delay line: STAGES register stages, valid and data move together.
module deskew_lane #(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  generate
    if (STAGES == 0) begin : g_pass
      assign out_vld  = in_vld;
      assign out_data = in_data;
    end else begin : g_dly
      logic [STAGES-1:0]             vld_pipe;
      logic [STAGES-1:0][DATA_W-1:0] dat_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_vld;
          dat_pipe[0] <= in_data;
          for (int s = 1; s < STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
          end
        end
      end

      assign out_vld  = vld_pipe[STAGES-1];
      assign out_data = dat_pipe[STAGES-1];
    end
  endgenerate
endmodule

module softmax_row_feeder #(
  parameter int ARRAYWIDTH = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  softmax_row_feeder_if.slave  bus,
  input  logic                 clr_flags,
  output logic                 overflow,
  output logic                 skew_err,
  output logic [15:0]          row_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ARRAYWIDTH-1:0]             al_vld;
  logic [ARRAYWIDTH-1:0][DATA_W-1:0] al_data;

  // Column j waits ARRAYWIDTH-1-j cycles so it meets the last column.
  generate
    for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_lane
      deskew_lane #(.DATA_W(DATA_W), .STAGES(ARRAYWIDTH-1-j)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bus.col_valid[j]),
        .in_data  (bus.col_data[DATA_W*j +: DATA_W]),
        .out_vld  (al_vld[j]),
        .out_data (al_data[j])
      );
    end
  endgenerate

  logic row_done, row_bad;
  assign row_done = &al_vld;
  assign row_bad  = (|al_vld) & ~row_done;

  logic [DEPTH-1:0][ARRAYWIDTH*DATA_W-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic empty, full, pop, push, drop;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign pop   = ~empty & bus.softmax_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a row.
  assign push  = row_done & (~full | pop);
  assign drop  = row_done & full & ~pop;

  assign bus.softmax_en = ~empty;
  assign bus.Xi         = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: it is only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= al_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
      row_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        row_cnt <= row_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (row_bad)        skew_err <= 1'b1;
      else if (clr_flags) skew_err <= 1'b0;
    end
  end
endmodule

// File: doc/softmax_row_feeder.md
# softmax_row_feeder

Deskew-and-buffer stage directly upstream of `softmax`. It collects the time-skewed per-column results of the systolic array output buffer and realigns them into complete rows. Complete rows are queued in a small FIFO and presented to `softmax` as one packed `Xi` vector qualified by `softmax_en`, with a valid/ready handshake. It also reports FIFO overflow, skew errors and a delivered-row count.

## Interface
Parameters:
- ARRAYWIDTH, 4: number of systolic columns (elements per row).
- DATA_W, 32: element width; equals `OUTPUT_BUF_DATASIZE`.
- DEPTH, 4: row FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- col_valid  in  ARRAYWIDTH  per-column result strobe from the output buffer.
- col_data  in  ARRAYWIDTH*DATA_W  per-column results; column j sits at [DATA_W*j +: DATA_W].
- Xi  out  ARRAYWIDTH*DATA_W  aligned row to softmax, same packing as col_data.
- softmax_en  out  1  Xi valid.
- softmax_ready  in  1  softmax accepts Xi this cycle.
- clr_flags  in  1  synchronous clear of the sticky flags.
- overflow  out  1  sticky: a complete row was dropped because the FIFO was full.
- skew_err  out  1  sticky: aligned valids were not all equal.
- row_cnt  out  16  rows handed to softmax; wraps modulo 2^16.

## Operation
- Skew contract: the element of row r for column j is presented with col_valid[j]=1 exactly j cycles after column 0 of the same row.
- Deskew: column j passes through ARRAYWIDTH-1-j register stages (valid and data together). Column ARRAYWIDTH-1 passes through none. The outputs of the stages form the aligned row.
- Row complete: every aligned valid bit is 1. The aligned row is then written into the FIFO at the next edge.
- Partial alignment, meaning some aligned valid bits are 1 and others 0: set skew_err, discard the row, and write nothing.
- FIFO: DEPTH entries with show-ahead output. Xi equals the head entry, and softmax_en = not empty.
- Pop: at an edge where softmax_en and softmax_ready are both 1. row_cnt increments on every pop.
- Push when full with no pop in the same cycle: the row is dropped, overflow is set, and FIFO contents are unchanged.
- Push when full with a pop in the same cycle: the push is accepted, and occupancy stays at DEPTH.
- Push and pop in the same cycle at any other occupancy: both take effect, and occupancy is unchanged.
- Xi is held stable while softmax_en=1 and softmax_ready=0.
- clr_flags=1 clears overflow and skew_err at the next edge. If a new flag event occurs in the same cycle, the event wins and the flag is set.
- No arithmetic on the data. Elements are passed bit-exact. Signed interpretation is downstream's concern.

## Timing
- Reset: all deskew valids cleared, FIFO empty, softmax_en=0, Xi=0, overflow=0, skew_err=0, row_cnt=0.
- Reset mid-row: any partially deskewed row is lost, and no skew_err is raised for it after reset release.
- Latency, FIFO empty: col_valid[0] high in cycle t0 gives softmax_en=1 in cycle t0+ARRAYWIDTH (4 cycles at default). This is ARRAYWIDTH-1 deskew stages plus one FIFO write.
- Throughput: one row per cycle sustained when softmax_ready is held at 1. There are no bubbles between back-to-back rows.
- Backpressure: at most DEPTH rows are buffered. The row in flight in the deskew stages is not stalled. It is dropped per the overflow rule if there is no room.
- Flags and row_cnt are registered outputs and update one edge after the causing event.

## Test plan
- Single row: at ARRAYWIDTH=4, present elements 1, 2, 3, 4 with the correct skew starting at t0, with softmax_ready=1.
  - Required: softmax_en pulses for exactly one cycle at t0+4, with Xi=128'h00000004_00000003_00000002_00000001.
  - Required: row_cnt=1, and no flags are set.
- Back-to-back: 8 skewed rows on consecutive cycles with the ready signal high.
  - Required: softmax_en is high for 8 consecutive cycles, and the rows appear in order.
  - Required: row_cnt=8.
- Backpressure/overflow: softmax_ready=0 while 5 rows enter.
  - Required: the FIFO holds the first 4 rows, the 5th row is dropped, and overflow=1.
  - Then raise the ready signal. Required: exactly rows 1–4 are delivered, and overflow stays 1 until clr_flags is pulsed.
- Full with a simultaneous pop: the FIFO is full, softmax_ready=1, and a new row completes in the same cycle.
  - Required: the row is accepted, overflow=0, and occupancy remains 4.
- Skew violation: assert col_valid[3] one cycle early for a row.
  - Required: skew_err=1, that row is not delivered, and the following well-formed rows are delivered normally.
- Async reset mid-row: assert rst two cycles after col_valid[0].
  - Required: all outputs go to their reset values immediately.
  - Required: no row is delivered and no flag is set after release, and a fresh row afterwards is delivered with 4-cycle latency.
